input_debouncer: RTL

//  Conditions raw asynchronous switch/button inputs before they drive the logic-gate designs (a/b inputs).
//  Per channel: two-flop synchroniser, then a stability counter. Emits a clean, glitch-free level.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_channel.sv | 56 +++++
 rtl/input_debouncer.sv | 58 +++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the input debouncer.
// Optional DEBOUNCE_EDGE_EN (used in input_debouncer) enables per-channel edge pulses.
package debounce_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int SIM_DEBOUNCE_CYCLES     = 4;

   function automatic int cnt_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: two-flop synchroniser, stability counter and the clean level.
// o_upd is high on the edge where o_clean takes the new value.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_clean,
   output logic o_upd
);

   localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_clean;
   logic [CW-1:0] r_cnt;
   logic          w_diff;
   logic          w_done;

   assign w_diff = r_sync2 ^ r_clean;
   assign w_done = w_diff && (r_cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Any cycle where the synchronised input agrees with the output abandons the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_clean <= 1'b0;
      end else if (!w_diff) begin
         r_cnt   <= '0;
      end else if (w_done) begin
         r_cnt   <= '0;
         r_clean <= r_sync2;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign o_clean = r_clean;
   assign o_upd   = w_done;

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel switch debouncer with a shared change strobe.
// Define DEBOUNCE_EDGE_EN to build per-channel rise/fall pulses; otherwise they read 0.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int NUM_CH          = 2,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] raw_in,
   output logic [NUM_CH-1:0] clean_out,
   output logic              changed,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse
);

   logic [NUM_CH-1:0] w_clean;
   logic [NUM_CH-1:0] w_upd;
   logic              r_changed;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_raw  (raw_in[g]),
         .o_clean(w_clean[g]),
         .o_upd  (w_upd[g])
      );
   end

   // Registered alongside the clean bits so the strobe lines up with the new level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_changed <= 1'b0;
      else        r_changed <= |w_upd;
   end

`ifdef DEBOUNCE_EDGE_EN
   logic [NUM_CH-1:0] r_clean_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_clean_d <= '0;
      else        r_clean_d <= w_clean;
   end

   assign rise_pulse = w_clean & ~r_clean_d;
   assign fall_pulse = ~w_clean & r_clean_d;
`else
   assign rise_pulse = '0;
   assign fall_pulse = '0;
`endif

   assign clean_out = w_clean;
   assign changed   = r_changed;

endmodule
